rbm_iteration_scheduler: RTL and testbench



---
 rtl/rbm_sched_pkg.sv | 28 ++
 rtl/rbm_iteration_scheduler_acc.sv | 28 ++
 rtl/rbm_iteration_scheduler.sv | 128 ++++++++++++
 tb/tb_rbm_iteration_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rbm_sched_pkg.sv
// Shared types and helpers for the RBM iteration scheduler: state encoding,
// default saturation bound and the clamped signed add used by every accumulator.
package rbm_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    ARGMAX = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [11:0] INF_DEFAULT = 12'b0111_1111_1111;

  function automatic int sat_lo(input int hi);
    return -hi;
  endfunction

  // Operands are sign-extended to 32 bits, so the sum cannot wrap before clamping.
  function automatic int sat_add(input int a, input int b, input int hi);
    int sum;
    sum = a + b;
    if (sum > hi) return hi;
    if (sum < sat_lo(hi)) return sat_lo(hi);
    return sum;
  endfunction

endpackage

// File: rtl/rbm_iteration_scheduler_acc.sv
// Single-class saturating accumulator: synchronous clear, enable-gated
// clamped signed add of one per-pass class value.
module rbm_sat_accumulator
  import rbm_sched_pkg::*;
#(
  parameter int unsigned          bitlength = 12,
  parameter logic [bitlength-1:0] Inf       = bitlength'(INF_DEFAULT)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [bitlength-1:0] din,
  output logic [bitlength-1:0] acc
);

  logic [bitlength-1:0] sum;

  always_comb begin
    sum = bitlength'(sat_add(int'($signed(acc)), int'($signed(din)), int'(Inf)));
  end

  always_ff @(posedge clock) begin
    if (reset || clear) acc <= '0;
    else if (enable)    acc <= sum;
  end

endmodule

// File: rtl/rbm_iteration_scheduler.sv
// Iteration scheduler for the two-layer stochastic RBM: per-pass layer reset,
// saturating class accumulation, sequential argmax. Optional early exit: RBM_EARLY_EXIT_EN.
module rbm_iteration_scheduler
  import rbm_sched_pkg::*;
#(
  parameter int unsigned          bitlength      = 12,
  parameter int unsigned          output_dim     = 10,
  parameter int unsigned          class_width    = 4,
  parameter logic [bitlength-1:0] Inf            = bitlength'(INF_DEFAULT),
  parameter int unsigned          iteration_num  = 100,
  parameter logic [bitlength-1:0] exit_threshold = bitlength'(1024)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            data_valid,
  input  logic                            layer_finish,
  input  logic [output_dim*bitlength-1:0] LayerOutput,
  output logic                            layer_reset,
  output logic                            busy,
  output logic [output_dim*bitlength-1:0] OutputData,
  output logic [class_width-1:0]          predicted_class,
  output logic [31:0]                     iter_count,
  output logic                            finish
);

`ifdef RBM_EARLY_EXIT_EN
  localparam bit early_exit = 1'b1;
`else
  localparam bit early_exit = 1'b0;
`endif

  state_t state, state_next;

  logic                        acc_clear, acc_en;
  logic                        last_pass, exit_hit, am_last, take;
  logic [class_width-1:0]      am_idx, best_idx, nb_idx;
  logic signed [bitlength-1:0] best_val, cand, nb_val;

  always_comb begin
    acc_clear = (state == IDLE || state == DONE) && data_valid;
    acc_en    = (state == RUN) && layer_finish;
  end

  for (genvar g = 0; g < int'(output_dim); g++) begin : g_acc
    rbm_sat_accumulator #(
      .bitlength(bitlength),
      .Inf      (Inf)
    ) u_acc (
      .clock (clock),
      .reset (reset),
      .clear (acc_clear),
      .enable(acc_en),
      .din   (LayerOutput[g*bitlength +: bitlength]),
      .acc   (OutputData[g*bitlength +: bitlength])
    );
  end

  // Early exit inspects the values the accumulators are about to take.
  always_comb begin
    exit_hit = 1'b0;
    for (int unsigned g = 0; g < output_dim; g++) begin
      if (sat_add(int'($signed(OutputData[g*bitlength +: bitlength])),
                  int'($signed(LayerOutput[g*bitlength +: bitlength])),
                  int'(Inf)) >= int'($signed(exit_threshold)))
        exit_hit = 1'b1;
    end
  end

  always_comb begin
    last_pass = (iter_count + 32'd1) == 32'(iteration_num);
    am_last   = am_idx == class_width'(output_dim - 1);
    cand      = $signed(OutputData[am_idx*bitlength +: bitlength]);
    take      = (am_idx == '0) || (cand > best_val);
    nb_val    = take ? cand   : best_val;
    nb_idx    = take ? am_idx : best_idx;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE:
        if (data_valid) state_next = (iteration_num == 0) ? ARGMAX : CLEAR;
      CLEAR:
        state_next = RUN;
      RUN:
        if (layer_finish)
          state_next = (last_pass || (early_exit && exit_hit)) ? ARGMAX : CLEAR;
      ARGMAX:
        if (am_last) state_next = DONE;
      default:
        state_next = IDLE;
    endcase
  end

  always_comb begin
    layer_reset = (state != RUN);
    busy        = (state == CLEAR) || (state == RUN) || (state == ARGMAX);
    finish      = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      iter_count      <= '0;
      predicted_class <= '0;
      am_idx          <= '0;
      best_idx        <= '0;
      best_val        <= '0;
    end else begin
      if (acc_clear) iter_count <= '0;
      else if (acc_en) iter_count <= iter_count + 32'd1;

      if (state == ARGMAX) begin
        am_idx   <= am_idx + 1'b1;
        best_val <= nb_val;
        best_idx <= nb_idx;
        if (am_last) predicted_class <= nb_idx;
      end else begin
        am_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rbm_iteration_scheduler.sv
// Self-checking bench for rbm_iteration_scheduler: cycle-level reference model,
// per-cycle compare, plus literal checks of the documented scenarios.
module tb_rbm_iteration_scheduler;

  localparam int BL  = 12;
  localparam int OD  = 10;
  localparam int CW  = 4;
  localparam int N   = 3;
  localparam int LAT = 2;
  localparam int HI  = 2047;
  localparam int THR = 1024;
`ifdef RBM_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, data_valid, layer_finish, layer_reset, busy, finish;
  logic [OD*BL-1:0] layer_output, output_data;
  logic [CW-1:0]    predicted_class;
  logic [31:0]      iter_count;

  logic dv2, lf2, layer_reset2, busy2, finish2;
  logic [OD*BL-1:0] layer_output2, output_data2;
  logic [CW-1:0]    predicted_class2;
  logic [31:0]      iter_count2;

  logic spur, rf1, rf2;
  int   rc1, rc2;
  int   vectors = 0, miscompares = 0;
  bit   chk_en = 1'b0;

  always #5 clock = ~clock;

  assign layer_finish = rf1 | spur;
  assign lf2          = rf2;

  rbm_iteration_scheduler #(.bitlength(BL), .output_dim(OD), .class_width(CW),
                            .iteration_num(N)) dut (
    .clock(clock), .reset(reset), .data_valid(data_valid), .layer_finish(layer_finish),
    .LayerOutput(layer_output), .layer_reset(layer_reset), .busy(busy),
    .OutputData(output_data), .predicted_class(predicted_class),
    .iter_count(iter_count), .finish(finish));

  rbm_iteration_scheduler #(.bitlength(BL), .output_dim(OD), .class_width(CW),
                            .iteration_num(100)) dut100 (
    .clock(clock), .reset(reset), .data_valid(dv2), .layer_finish(lf2),
    .LayerOutput(layer_output2), .layer_reset(layer_reset2), .busy(busy2),
    .OutputData(output_data2), .predicted_class(predicted_class2),
    .iter_count(iter_count2), .finish(finish2));

  // Layer stand-in: reports a pass complete LAT cycles after its reset is released.
  always @(posedge clock) begin
    #2;
    if (!layer_reset)  begin rc1++; rf1 = (rc1 == LAT); end else begin rc1 = 0; rf1 = 1'b0; end
    if (!layer_reset2) begin rc2++; rf2 = (rc2 == LAT); end else begin rc2 = 0; rf2 = 1'b0; end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: inference in progress, clear cycle pending, argmax cycles left.
  bit m_active, m_clear, m_done;
  int m_am, m_iter, m_pred, m_best;
  int m_acc [OD];

  function automatic int sclass(input logic [OD*BL-1:0] v, input int g);
    logic [BL-1:0] s;
    s = v[g*BL +: BL];
    return int'($signed(s));
  endfunction

  task automatic m_start_argmax();
    m_am   = OD;
    m_best = 0;
    for (int g = 1; g < OD; g++) if (m_acc[g] > m_acc[m_best]) m_best = g;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_active = 0; m_clear = 0; m_done = 0; m_am = 0; m_iter = 0; m_pred = 0;
      for (int g = 0; g < OD; g++) m_acc[g] = 0;
    end else if (m_am > 0) begin
      m_am--;
      if (m_am == 0) begin m_pred = m_best; m_done = 1; end
    end else if (m_active && m_clear) begin
      m_clear = 0;
    end else if (m_active) begin
      if (layer_finish) begin
        bit hit;
        hit = 0;
        for (int g = 0; g < OD; g++) begin
          int s;
          s = m_acc[g] + sclass(layer_output, g);
          m_acc[g] = (s > HI) ? HI : (s < -HI) ? -HI : s;
          if (m_acc[g] >= THR) hit = 1;
        end
        m_iter++;
        if (m_iter == N || (EE && hit)) begin m_active = 0; m_start_argmax(); end
        else m_clear = 1;
      end
    end else if (data_valid) begin
      for (int g = 0; g < OD; g++) m_acc[g] = 0;
      m_iter = 0; m_done = 0;
      m_active = 1; m_clear = 1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", busy, (m_active || m_am > 0));
      chk("layer_reset", layer_reset, !(m_active && !m_clear));
      chk("finish", finish, m_done);
      chk("iter_count", iter_count, m_iter);
      chk("predicted_class", predicted_class, m_pred);
      for (int g = 0; g < OD; g++)
        chk($sformatf("acc%0d", g), sclass(output_data, g), m_acc[g]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic set_all(input int v);
    for (int g = 0; g < OD; g++) layer_output[g*BL +: BL] = BL'(v);
  endtask

  task automatic set_class(input int g, input int v);
    layer_output[g*BL +: BL] = BL'(v);
  endtask

  task automatic start();
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
  endtask

  task automatic wait_finish(input int budget);
    int n;
    n = 0;
    while (!finish && n < budget) begin tick(1); n++; end
    chk("finish_wait", finish, 1);
  endtask

  initial begin
    reset = 1'b1; data_valid = 1'b0; spur = 1'b0; dv2 = 1'b0;
    layer_output = '0; layer_output2 = '0;
    tick(2);
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_layer_reset", layer_reset, 1);
    chk("rst_finish", finish, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_pred", predicted_class, 0);
    chk("rst_acc0", sclass(output_data, 0), 0);
    reset = 1'b0;
    tick(1);

    // Basic: class 2 leads
    set_all(10); set_class(2, 100);
    start();
    wait_finish(200);
    chk("t1_acc2", sclass(output_data, 2), 300);
    chk("t1_acc0", sclass(output_data, 0), 30);
    chk("t1_pred", predicted_class, 2);
    chk("t1_iter", iter_count, 3);
    tick(3);

    // Saturation both ways
    set_all(0); set_class(0, 1500); set_class(5, -1500);
    start();
    wait_finish(200);
    chk("t2_acc0", sclass(output_data, 0), EE ? 1500 : 2047);
    chk("t2_acc5", sclass(output_data, 5), EE ? -1500 : -2047);
    chk("t2_iter", iter_count, EE ? 1 : 3);
    chk("t2_pred", predicted_class, 0);

    // Tie between classes 3 and 7, restarted from DONE
    set_all(0); set_class(3, 50); set_class(7, 50);
    start();
    chk("t3_finish_drop", finish, 0);
    wait_finish(200);
    chk("t3_pred", predicted_class, 3);
    chk("t3_acc7", sclass(output_data, 7), 150);

    // Reset during pass 2, then spurious layer_finish in IDLE, then a clean run
    set_all(0); set_class(1, 20);
    start();
    begin
      int n;
      n = 0;
      while (!(iter_count == 1 && !layer_reset) && n < 100) begin tick(1); n++; end
      chk("t4_reach_pass2", (iter_count == 1 && !layer_reset), 1);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_layer_reset", layer_reset, 1);
    chk("t4_finish", finish, 0);
    chk("t4_acc1", sclass(output_data, 1), 0);
    chk("t4_iter", iter_count, 0);
    spur = 1'b1; tick(1); spur = 1'b0; tick(1);
    chk("t4_idle_spur_iter", iter_count, 0);
    chk("t4_idle_spur_busy", busy, 0);
    start();
    wait_finish(200);
    chk("t4_acc1_after", sclass(output_data, 1), 60);
    chk("t4_pred", predicted_class, 1);

    // Spurious finish in CLEAR, data_valid while RUN
    set_all(0); set_class(6, 7);
    start();
    spur = 1'b1; tick(1); spur = 1'b0;
    data_valid = 1'b1; tick(1); data_valid = 1'b0;
    tick(4);
    data_valid = 1'b1; tick(1); data_valid = 1'b0;
    wait_finish(200);
    chk("t5_iter", iter_count, 3);
    chk("t5_acc6", sclass(output_data, 6), 21);
    chk("t5_pred", predicted_class, 6);

    // 100-pass instance: early exit or full run
    layer_output2[4*BL +: BL] = BL'(600);
    dv2 = 1'b1; tick(1); dv2 = 1'b0;
    begin
      int n;
      n = 0;
      while (!finish2 && n < 1500) begin tick(1); n++; end
      chk("t6_finish_wait", finish2, 1);
    end
    chk("t6_iter", iter_count2, EE ? 2 : 100);
    chk("t6_pred", predicted_class2, 4);
    chk("t6_acc4", sclass(output_data2, 4), EE ? 1200 : 2047);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
